// File: rtl/cache_pkg.sv
// +----------------------------------------------------------------------------+
// | cache_pkg : shared types and backing_store encodings for dm_cache_ctrl     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package cache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    RESP     = 2'd3
  } state_e;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cache_line_array.sv
// +----------------------------------------------------------------------------+
// | cache_line_array : valid/tag/data storage, async read, sync write          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cache_line_array #(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [31:0]      rd_data_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [31:0]      wr_data_i,
  input  logic             wr_set_valid_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];

  // Only the valid bits are reset; tag/data contents are don't-care until filled.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en_i && wr_set_valid_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/dm_cache_ctrl.sv
// +----------------------------------------------------------------------------+
// | dm_cache_ctrl : direct-mapped write-through no-write-allocate word cache   |
// | Optional read hit/miss counters enabled by CACHE_STATS_EN.                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module dm_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int NUM_LINES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic              cpu_req_we,
  input  logic [31:0]       cpu_req_wdata,
  output logic              cpu_resp_valid,
  output logic [31:0]       cpu_resp_data,
  output logic [31:0]       mem_req_addr,
  output logic [31:0]       mem_req_data,
  output logic              mem_req_type,
  output logic              mem_req_do,
  input  logic [31:0]       mem_O_data,
  input  logic              mem_req_done,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       resp_data_q, resp_data_d;

  logic [IDX_W-1:0]  idx_in;
  logic [TAG_W-1:0]  tag_in;
  logic              lk_valid;
  logic [TAG_W-1:0]  lk_tag;
  logic [31:0]       lk_data;
  logic              hit;
  logic              accept;

  logic              arr_we;
  logic [IDX_W-1:0]  arr_idx;
  logic [TAG_W-1:0]  arr_tag;
  logic [31:0]       arr_data;
  logic              arr_set_valid;

  logic              unused_addr_bits;

  assign idx_in           = cpu_req_addr[IDX_W+1:2];
  assign tag_in           = cpu_req_addr[ADDR_W-1:IDX_W+2];
  assign unused_addr_bits = ^cpu_req_addr[1:0];
  assign hit              = lk_valid && (lk_tag == tag_in);
  assign accept           = cpu_req_valid && (state_q == IDLE);

  cache_line_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_lines (
    .clk            (clk),
    .reset          (reset),
    .rd_idx_i       (idx_in),
    .rd_valid_o     (lk_valid),
    .rd_tag_o       (lk_tag),
    .rd_data_o      (lk_data),
    .wr_en_i        (arr_we),
    .wr_idx_i       (arr_idx),
    .wr_tag_i       (arr_tag),
    .wr_data_i      (arr_data),
    .wr_set_valid_i (arr_set_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= REQ_READ;
      wdata_q     <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      resp_data_q <= resp_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    resp_data_d   = resp_data_q;
    arr_we        = 1'b0;
    arr_idx       = idx_in;
    arr_tag       = tag_in;
    arr_data      = cpu_req_wdata;
    arr_set_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          addr_d  = cpu_req_addr;
          we_d    = cpu_req_we;
          wdata_d = cpu_req_wdata;
          if (cpu_req_we == REQ_WRITE) begin
            // Write-through: a write hit refreshes the line now, a miss leaves it alone.
            arr_we  = hit;
            state_d = MEM_REQ;
          end else if (hit) begin
            resp_data_d = lk_data;
            state_d     = RESP;
          end else begin
            state_d = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_req_done) begin
          state_d = RESP;
          if (we_q == REQ_WRITE) begin
            resp_data_d = '0;
          end else begin
            resp_data_d   = mem_O_data;
            arr_we        = 1'b1;
            arr_idx       = addr_q[IDX_W+1:2];
            arr_tag       = addr_q[ADDR_W-1:IDX_W+2];
            arr_data      = mem_O_data;
            arr_set_valid = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cpu_req_ready  = (state_q == IDLE);
  assign cpu_resp_valid = (state_q == RESP);
  assign cpu_resp_data  = resp_data_q;
  assign mem_req_do     = (state_q == MEM_REQ);
  assign mem_req_addr   = 32'(addr_q);
  assign mem_req_data   = wdata_q;
  assign mem_req_type   = we_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (accept && (cpu_req_we == REQ_READ)) begin
      if (hit && (hits_q != '1)) begin
        hits_q <= hits_q + 32'd1;
      end
      if (!hit && (misses_q != '1)) begin
        misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign stat_hits     = '0;
  assign stat_misses   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_cache_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_dm_cache_ctrl : directed + randomized bench with backing_store model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_dm_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic [31:0] cpu_req_addr = '0;
  logic        cpu_req_we = 1'b0;
  logic [31:0] cpu_req_wdata = '0;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_data;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_req_type;
  logic        mem_req_do;
  logic [31:0] mem_O_data = '0;
  logic        mem_req_done = 1'b0;
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;

  int checks = 0;
  int errors = 0;

  // Flat memories: what backing_store holds, and what the CPU should observe.
  logic [31:0] bs_mem [logic [31:0]];
  logic [31:0] gold   [logic [31:0]];
  // Which word address currently occupies each line.
  logic [31:0] cached [int];
  int unsigned ref_hits = 0;
  int unsigned ref_misses = 0;

  dm_cache_ctrl #(
    .ADDR_W    (32),
    .NUM_LINES (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_data  (cpu_resp_data),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_type   (mem_req_type),
    .mem_req_do     (mem_req_do),
    .mem_O_data     (mem_O_data),
    .mem_req_done   (mem_req_done),
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] bs_rd(input logic [31:0] a);
    return bs_mem.exists(word(a)) ? bs_mem[word(a)] : 32'h0;
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(word(a)) ? gold[word(a)] : 32'h0;
  endfunction

  // backing_store: done arrives 4 cycles after the req_do cycle; addr/data must hold.
  int          rsp_cnt = 0;
  logic [31:0] rsp_addr = '0;
  logic [31:0] rsp_data = '0;
  logic        rsp_type = 1'b0;

  always @(posedge clk) begin : p_backing_store
    logic s_rst, s_do, s_done;
    s_rst  = reset;
    s_do   = mem_req_do;
    s_done = mem_req_done;
    if (!s_rst && (rsp_cnt != 0 || s_done)) begin
      check("mem_addr_hold", mem_req_addr, rsp_addr);
      if (rsp_type) check("mem_data_hold", mem_req_data, rsp_data);
      check("mem_do_while_busy", {31'd0, s_do}, 32'd0);
    end
    #1;
    mem_req_done = 1'b0;
    mem_O_data   = $urandom;
    if (s_rst) begin
      rsp_cnt = 0;
    end else if (rsp_cnt != 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        mem_req_done = 1'b1;
        if (rsp_type) bs_mem[word(rsp_addr)] = rsp_data;
        else          mem_O_data = bs_rd(rsp_addr);
      end
    end else if (s_do) begin
      rsp_addr = mem_req_addr;
      rsp_data = mem_req_data;
      rsp_type = mem_req_type;
      rsp_cnt  = 3;
    end
  end

  task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
    check({tag, "_hits"},   stat_hits,   ref_hits);
    check({tag, "_misses"}, stat_misses, ref_misses);
`else
    check({tag, "_hits"},   stat_hits,   32'd0);
    check({tag, "_misses"}, stat_misses, 32'd0);
`endif
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cpu_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cached.delete();
    ref_hits   = 0;
    ref_misses = 0;
  endtask

  task automatic do_req(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                        input string tag);
    logic [31:0] wa, exp_data;
    int          idx, lat, n_do;
    bit          exp_hit;
    wa       = word(addr);
    idx      = int'(addr[5:2]);
    exp_hit  = !we && cached.exists(idx) && (cached[idx] == wa);
    exp_data = we ? 32'h0 : gold_rd(wa);

    check({tag, "_ready"}, {31'd0, cpu_req_ready}, 32'd1);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = addr;
    cpu_req_we    = we;
    cpu_req_wdata = wd;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    cpu_req_addr  = $urandom;
    cpu_req_we    = 1'($urandom);
    cpu_req_wdata = $urandom;

    check({tag, "_busy"}, {31'd0, cpu_req_ready}, 32'd0);
    check({tag, "_do_c1"}, {31'd0, mem_req_do}, {31'd0, !exp_hit});
    if (!exp_hit) begin
      check({tag, "_mem_addr"}, mem_req_addr, addr);
      check({tag, "_mem_type"}, {31'd0, mem_req_type}, {31'd0, we});
      if (we) check({tag, "_mem_data"}, mem_req_data, wd);
    end

    lat  = 1;
    n_do = 0;
    while (!cpu_resp_valid && lat < 20) begin
      if (mem_req_do) n_do++;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_hit ? 32'd1 : 32'd6);
    check({tag, "_do_count"}, n_do, exp_hit ? 32'd0 : 32'd1);
    check({tag, "_resp_data"}, cpu_resp_data, exp_data);

    @(posedge clk);
    #1;
    check({tag, "_strobe_1cyc"}, {31'd0, cpu_resp_valid}, 32'd0);
    check({tag, "_data_hold"}, cpu_resp_data, exp_data);

    if (!we) begin
      cached[idx] = wa;
      if (exp_hit) ref_hits++;
      else         ref_misses++;
    end else begin
      gold[wa] = wd;
    end
    check_stats(tag);
  endtask

  initial begin : p_main
    bit quiet;
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, cpu_req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
    check("rst_resp_data", cpu_resp_data, 32'd0);
    check("rst_mem_do", {31'd0, mem_req_do}, 32'd0);
    check("rst_mem_addr", mem_req_addr, 32'd0);
    check("rst_mem_data", mem_req_data, 32'd0);
    check("rst_mem_type", {31'd0, mem_req_type}, 32'd0);
    check_stats("rst");
    reset = 1'b0;

    // Directed scenarios
    do_req(32'h40, 1'b0, 32'h0,        "cold_rd_40");
    do_req(32'h40, 1'b0, 32'h0,        "hit_rd_40");
    do_req(32'h40, 1'b1, 32'hDEADBEEF, "wr_hit_40");
    do_req(32'h40, 1'b0, 32'h0,        "rd_after_wr_40");
    do_req(32'h80, 1'b1, 32'h12345678, "wr_miss_80");
    do_req(32'h80, 1'b0, 32'h0,        "rd_miss_80");
    do_req(32'h80, 1'b0, 32'h0,        "rd_hit_80");
    do_req(32'h04, 1'b0, 32'h0,        "conf_rd_04");
    do_req(32'h44, 1'b0, 32'h0,        "conf_rd_44");
    do_req(32'h04, 1'b0, 32'h0,        "conf_rd_04_again");

    // Reset during MEM_WAIT of a read miss
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h100;
    cpu_req_we    = 1'b0;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    cached.delete();
    ref_hits   = 0;
    ref_misses = 0;
    check("midrst_ready", {31'd0, cpu_req_ready}, 32'd1);
    check("midrst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
    check("midrst_mem_do", {31'd0, mem_req_do}, 32'd0);
    quiet = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (cpu_resp_valid || mem_req_do) quiet = 1'b0;
    end
    check("midrst_quiet", {31'd0, quiet}, 32'd1);
    do_req(32'h80, 1'b0, 32'h0, "midrst_reread_80");

    // Randomized traffic over 4 tags x 16 lines with preloaded memory
    apply_reset();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) begin
        logic [31:0] a, v;
        a = (32'(t) << 6) | (32'(i) << 2);
        v = $urandom;
        bs_mem[a] = v;
        gold[a]   = v;
      end
    end
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
        check("idle_no_resp", {31'd0, cpu_resp_valid}, 32'd0);
      end
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
          | 32'($urandom_range(0, 3));
      do_req(a, ($urandom_range(0, 3) == 0), $urandom, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate word cache between the CPU data port and backing_store.
- Serves read hits locally in one cycle.
- Issues single-word read or write transactions on the backing_store request interface (req_do / req_done) for misses and for all writes.
- One outstanding transaction at a time.

Parameters:
- ADDR_W, 32, CPU/memory byte-address width.
- NUM_LINES, 16, number of one-word lines; power of two, at least 2.
- IDX_W, $clog2(NUM_LINES), index width (derived; not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_ready  out  1  controller can accept a request (IDLE only).
- cpu_req_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_req_we  in  1  1 = write, 0 = read.
- cpu_req_wdata  in  32  write data.
- cpu_resp_valid  out  1  one-cycle response strobe.
- cpu_resp_data  out  32  read data; 0 for writes.
- mem_req_addr  out  32  to backing_store req_addr.
- mem_req_data  out  32  to backing_store req_data.
- mem_req_type  out  1  to backing_store req_type (0 = read, 1 = write).
- mem_req_do  out  1  to backing_store req_do.
- mem_O_data  in  32  from backing_store O_data; valid only while mem_req_done = 1.
- mem_req_done  in  1  from backing_store req_done.
- stat_hits  out  32  read-hit counter (optional feature).
- stat_misses  out  32  read-miss counter (optional feature).

Behaviour:
- Single clock. Reset is synchronous and active-high. Ports are named clk and reset.
- Reset values:
  - state IDLE; all valid bits 0; tag/data arrays undefined.
  - cpu_req_ready 1, cpu_resp_valid 0, cpu_resp_data 0.
  - mem_req_do 0, mem_req_addr 0, mem_req_data 0, mem_req_type 0.
- Address split: index = addr[IDX_W+1:2]; tag = addr[ADDR_W-1:IDX_W+2].
- States:
  - IDLE:
    - ready = 1. Accept on valid & ready.
    - Register addr/we/wdata.
    - Hit = valid[index] & (tag match), combinational lookup.
    - Read hit: resp_data <= line data; go to RESP.
    - Read miss: go to MEM_REQ, type 0.
    - Write: go to MEM_REQ, type 1. On hit, update the line data in the same cycle. On miss, leave the array untouched (no allocate).
  - MEM_REQ:
    - mem_req_do = 1 for exactly this one cycle.
    - addr/data/type are driven from the registered request and held stable until done.
    - Go to MEM_WAIT.
  - MEM_WAIT:
    - mem_req_do = 0. Wait for mem_req_done.
    - On done with a read: capture mem_O_data into the line, set valid, write tag, resp_data <= mem_O_data.
    - On done with a write: resp_data <= 0.
    - Go to RESP.
  - RESP: cpu_resp_valid = 1 for exactly one cycle; go to IDLE.
- Latency, counted from the accept cycle C:
  - Read hit: resp at C+1.
  - Read miss and write: req_do at C+1; backing_store done at C+5; resp at C+6.
- cpu_req_ready = 0 outside IDLE. No response backpressure: the CPU must take the strobe.
- mem_req_data and mem_req_addr hold from MEM_REQ through the done cycle, because backing_store samples data one cycle after req_do.
- mem_req_done seen outside MEM_WAIT is ignored.
- cpu_resp_data holds its last value while resp_valid = 0.
- Reset mid-transaction returns to IDLE and invalidates all lines. backing_store shares the reset.
- Write to address A after a valid read of A: line updated, so a later read of A hits with the new data.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - stat_hits increments on each accepted read hit.
  - stat_misses increments on each accepted read miss.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: both ports are tied to 0 and no counters are synthesized.

Decomposition:
- Package cache_pkg:
  - state enum (IDLE, MEM_REQ, MEM_WAIT, RESP).
  - REQ_READ = 1'b0, REQ_WRITE = 1'b1, matching backing_store encoding.
- Sub-module cache_line_array:
  - valid/tag/data storage.
  - Combinational read port by index.
  - Synchronous write port: index, tag, data, set_valid.
  - Synchronous reset clears valid bits only.

Test Plan:
- Reset, then read 0x40 (cold) -> mem_req_do pulse at C+1 with addr 0x40, type 0; resp_valid at C+6 with data 0; stat_misses = 1.
- Read 0x40 again -> resp at C+1 with data 0, no mem_req_do; stat_hits = 1.
- Write 0x40 = 0xDEADBEEF -> mem write, data held stable through done, resp at C+6 with data 0. Then read 0x40 -> hit, returns 0xDEADBEEF.
- Write 0x80 = 0x12345678 (miss, no allocate), then read 0x80 -> miss, memory fetch returns 0x12345678; line is then valid.
- Conflict: read 0x04, then read 0x44 (same index, NUM_LINES = 16) -> second read misses and evicts. Read 0x04 -> misses again.
- Assert reset during MEM_WAIT of a read -> next cycle IDLE, ready = 1, resp_valid = 0. Re-read of a previously cached address misses.
